// File: rtl/minilcd_pkg.sv
// Shared definitions for the MiniLCD panel receiver: command codes, FSM encoding
// and the registered bus-sample record used by the front end.
package minilcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_CASET = 3'd1;
  localparam rx_state_t ST_RASET = 3'd2;
  localparam rx_state_t ST_RAMWR = 3'd3;
  localparam rx_state_t ST_SKIP  = 3'd4;

  typedef struct packed {
    logic       rstb;
    logic       cs0;
    logic       cd;
    logic       wr;
    logic [7:0] d;
  } lcd_bus_t;

  // Bus at rest: panel out of reset, deselected, strobe high.
  localparam lcd_bus_t BUS_IDLE = '{rstb: 1'b1, cs0: 1'b1, cd: 1'b0, wr: 1'b1, d: 8'h00};

endpackage

// File: rtl/minilcd_rx_frontend.sv
// Bus front end: registers the LCD pins, detects the WR rising edge, flags panel reset.
// Define MINILCD_RX_SYNC_EN to add a two-flop synchronizer ahead of the sample stage.
module minilcd_rx_frontend
  import minilcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_lcd_rstb,
  input  logic       i_lcd_cs0,
  input  logic       i_lcd_cd,
  input  logic       i_lcd_wr,
  input  logic [7:0] i_lcd_d,
  output logic       o_byte_valid,
  output logic       o_byte_cd,
  output logic [7:0] o_byte_data,
  output logic       o_hw_rst
);

  lcd_bus_t w_bus;
  lcd_bus_t w_pre;
  lcd_bus_t r_s1;
  logic     r_s2_wr;

  assign w_bus = '{rstb: i_lcd_rstb, cs0: i_lcd_cs0, cd: i_lcd_cd, wr: i_lcd_wr, d: i_lcd_d};

`ifdef MINILCD_RX_SYNC_EN
  lcd_bus_t r_meta;
  lcd_bus_t r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= BUS_IDLE;
      r_sync <= BUS_IDLE;
    end else begin
      r_meta <= w_bus;
      r_sync <= r_meta;
    end
  end

  assign w_pre = r_sync;
`else
  assign w_pre = w_bus;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= BUS_IDLE;
      r_s2_wr <= 1'b1;
    end else begin
      r_s1    <= w_pre;
      r_s2_wr <= r_s1.wr;
    end
  end

  assign o_byte_valid = r_s1.wr & ~r_s2_wr & ~r_s1.cs0;
  assign o_byte_cd    = r_s1.cd;
  assign o_byte_data  = r_s1.d;
  assign o_hw_rst     = ~r_s1.rstb;

endmodule

// File: rtl/minilcd_panel_rx.sv
// MiniLCD panel-side receiver: decodes command/parameter bytes, tracks the address
// window and emits RGB565 pixel writes. Optional MINILCD_RX_SYNC_EN adds input sync.
//
// state    | meaning
// ST_IDLE  | no command in progress, data bytes ignored
// ST_CASET | collecting column start/end parameters
// ST_RASET | collecting row start/end parameters
// ST_RAMWR | pairing data bytes into pixels
// ST_SKIP  | unknown or finished command, data bytes ignored
module minilcd_panel_rx
  import minilcd_pkg::*;
#(
  parameter logic [7:0] MAX_COL = 8'd131,
  parameter logic [7:0] MAX_ROW = 8'd161
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lcd_rstb,
  input  logic        i_lcd_cs0,
  input  logic        i_lcd_cd,
  input  logic        i_lcd_wr,
  input  logic [7:0]  i_lcd_d,
  output logic        o_pix_we,
  output logic [7:0]  o_pix_x,
  output logic [7:0]  o_pix_y,
  output logic [15:0] o_pix_data,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_code,
  output logic        o_disp_on,
  output logic        o_sleep
);

  logic       w_byte_valid, w_byte_cd, w_hw_rst;
  logic [7:0] w_byte_data;
  logic       w_cmd, w_swreset, w_any_rst;

  rx_state_t  r_state;
  logic [1:0] r_idx;
  logic       r_hi_flag;
  logic [7:0] r_hi_byte;
  logic [7:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;

  minilcd_rx_frontend u_frontend (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lcd_rstb   (i_lcd_rstb),
    .i_lcd_cs0    (i_lcd_cs0),
    .i_lcd_cd     (i_lcd_cd),
    .i_lcd_wr     (i_lcd_wr),
    .i_lcd_d      (i_lcd_d),
    .o_byte_valid (w_byte_valid),
    .o_byte_cd    (w_byte_cd),
    .o_byte_data  (w_byte_data),
    .o_hw_rst     (w_hw_rst)
  );

  assign w_cmd     = w_byte_valid & ~w_byte_cd;
  assign w_swreset = w_cmd && (w_byte_data == CMD_SWRESET);
  assign w_any_rst = i_rst | w_hw_rst | w_swreset;

  always_ff @(posedge i_clk) begin
    if (w_any_rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_hi_flag   <= 1'b0;
      r_hi_byte   <= 8'h00;
      r_xs        <= 8'h00;
      r_xe        <= MAX_COL;
      r_ys        <= 8'h00;
      r_ye        <= MAX_ROW;
      r_x         <= 8'h00;
      r_y         <= 8'h00;
      o_pix_we    <= 1'b0;
      o_pix_x     <= 8'h00;
      o_pix_y     <= 8'h00;
      o_pix_data  <= 16'h0000;
      o_disp_on   <= 1'b0;
      o_sleep     <= 1'b1;
      // Software reset still reports itself on the command interface.
      o_cmd_valid <= w_swreset & ~i_rst & ~w_hw_rst;
      o_cmd_code  <= (w_swreset & ~i_rst & ~w_hw_rst) ? CMD_SWRESET : 8'h00;
    end else begin
      o_pix_we    <= 1'b0;
      o_cmd_valid <= 1'b0;
      if (w_cmd) begin
        o_cmd_valid <= 1'b1;
        o_cmd_code  <= w_byte_data;
        r_hi_flag   <= 1'b0;
        r_state     <= ST_IDLE;
        case (w_byte_data)
          CMD_SLPOUT:  o_sleep   <= 1'b0;
          CMD_SLPIN:   o_sleep   <= 1'b1;
          CMD_DISPON:  o_disp_on <= 1'b1;
          CMD_DISPOFF: o_disp_on <= 1'b0;
          CMD_CASET: begin
            r_state <= ST_CASET;
            r_idx   <= 2'd0;
          end
          CMD_RASET: begin
            r_state <= ST_RASET;
            r_idx   <= 2'd0;
          end
          CMD_RAMWR: begin
            r_state <= ST_RAMWR;
            r_x     <= r_xs;
            r_y     <= r_ys;
          end
          default:     r_state   <= ST_SKIP;
        endcase
      end else if (w_byte_valid) begin
        case (r_state)
          ST_CASET, ST_RASET: begin
            r_idx <= r_idx + 2'd1;
            // Only the low address bytes matter with 8-bit addressing.
            if (r_idx == 2'd1) begin
              if (r_state == ST_CASET) r_xs <= w_byte_data;
              else                     r_ys <= w_byte_data;
            end else if (r_idx == 2'd3) begin
              if (r_state == ST_CASET) r_xe <= w_byte_data;
              else                     r_ye <= w_byte_data;
              r_state <= ST_SKIP;
            end
          end
          ST_RAMWR: begin
            if (!r_hi_flag) begin
              r_hi_byte <= w_byte_data;
              r_hi_flag <= 1'b1;
            end else begin
              r_hi_flag  <= 1'b0;
              o_pix_we   <= 1'b1;
              o_pix_data <= {r_hi_byte, w_byte_data};
              o_pix_x    <= r_x;
              o_pix_y    <= r_y;
              if (r_x >= r_xe) begin
                r_x <= r_xs;
                r_y <= (r_y >= r_ye) ? r_ys : r_y + 8'd1;
              end else begin
                r_x <= r_x + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
